player_mover: RTL and testbench
===============================

# player_mover

Sequential token animator sitting directly upstream of the player sprite renderer. On a dice result it walks one player's token tile by tile along a serpentine board path, gliding a fixed number of pixels per video frame. It drives the renderer's `player_x`/`player_y` sprite-origin inputs. One instance exists per player.

## Interface
Parameters:
- `NUM_TILES`, 32: board path length; tile `NUM_TILES-1` is the goal.
- `COLS`, 8: tiles per board row.
- `TILE_PX`, 32: tile pitch in pixels.
- `ORIGIN_X`, 64: screen x of tile 0's top-left corner.
- `ORIGIN_Y`, 96: screen y of tile 0's top-left corner.
- `SPEED`, 4: pixels moved per `frame_tick`.
- `DWELL_FRAMES`, 6: pause between hops; used only with the macro.

Ports:
- `clk` in 1: pixel/system clock. One clock domain only.
- `reset` in 1: asynchronous, active-high reset.
- `frame_tick` in 1: one-cycle pulse, once per frame at the start of vblank.
- `move_start` in 1: one-cycle request to start a move.
- `steps` in 3: hop count, 0..7, sampled with `move_start`.
- `home` in 1: one-cycle pulse that returns the token to tile 0.
- `player_x` out 10: sprite top-left x, registered.
- `player_y` out 10: sprite top-left y, registered.
- `tile_idx` out 5: current tile (the last tile reached).
- `busy` out 1: a move is in progress.
- `move_done` out 1: one-cycle completion pulse.
- `at_goal` out 1: token is on tile `NUM_TILES-1`.

## Operation
- Tile coordinates:
  - r = idx / COLS, c = idx % COLS; when r is odd, c = COLS-1-c.
  - x = ORIGIN_X + c·TILE_PX + (TILE_PX-16)/2.
  - y = ORIGIN_Y + r·TILE_PX + (TILE_PX-16)/2.
  - Adjacent tiles differ in exactly one axis.
- States: IDLE, HOP, DWELL (exists only with the macro), DONE.
- IDLE:
  - `home` forces tile 0 and its coordinates, and clears `at_goal`. It takes priority over a simultaneous `move_start`.
  - `move_start` latches `steps` into `remaining`.
  - If `remaining`=0 or `at_goal`=1, go to DONE with no motion. Otherwise target = tile_idx+1 and go to HOP.
- HOP:
  - On each `frame_tick`, the differing axis moves toward target by `SPEED`.
  - If the distance left is ≤ `SPEED`, the position snaps exactly to target.
  - When position equals target: `tile_idx`++ and `remaining`--.
  - Then, if `remaining`=0 or the new tile is the goal, go to DONE. Remaining steps past the goal are discarded.
  - Otherwise go to DWELL (macro on) or load the next target and stay in HOP.
- DWELL: count `DWELL_FRAMES` `frame_tick`s, then load the next target and go to HOP.
- DONE: assert `move_done` for one cycle, then go to IDLE.
- `move_start` and `home` are ignored outside IDLE.
- `at_goal` is a registered compare of `tile_idx` with `NUM_TILES-1`.

## Timing
- Reset values:
  - `player_x`=72, `player_y`=104 with the default parameters.
  - `tile_idx`=0; `busy`, `move_done` and `at_goal` all 0.
  - State = IDLE.
- `move_start` at cycle n gives `busy`=1 at n+1.
- The first pixel change happens on the first `frame_tick` strictly after n.
- Frames per hop = ceil(TILE_PX/SPEED), which is 8 with the defaults.
- Positions change only in the cycle after a `frame_tick`, so they never tear mid-frame.
- Coordinates and `tile_idx` update in the same cycle the hop completes.
- DONE cycle: `move_done`=1 and `busy`=0 in the same cycle.
- A zero-step move gives `move_done` at n+2.
- Without `frame_tick` the block stalls indefinitely while holding its position.
- `reset` mid-move: all outputs return to their reset values immediately.

## Configuration
- `PLAYER_MOVER_DWELL_EN` defined: the DWELL state exists and the token pauses `DWELL_FRAMES` frames on each intermediate tile. There is no dwell after the final hop.
- Undefined: the DWELL state and its counter are not built, and hops chain back to back.

## Structure
- `board_pkg` holds:
  - the mover state enum;
  - the default board constants;
  - the `SPRITE_PX`=16 constant.
- Sub-module `tile_coord_lut`: combinational tile index to (x,y) mapping, parameterized identically. It is reused by the board renderer.

## Test plan
All scenarios use the default parameters and `frame_tick` every 100 clocks.
- Reset: the token sits at (72,104), `tile_idx`=0, `busy`=0, `at_goal`=0. No motion occurs without `move_start`.
- `steps`=3 from tile 0: x rises 4 px per tick, and `move_done` arrives after 24 ticks with `tile_idx`=3 at (168,104).
- Row turn, from tile 6 with `steps`=2: the token reaches (296,104) at tile 7, then y rises to (296,136) at tile 8.
- Overshoot, from tile 29 with `steps`=5:
  - the token stops at tile 31, (72,200), with `at_goal`=1 and `move_done` after 2 hops;
  - a following `move_start` gives `move_done` with no motion.
- Ignored requests:
  - `steps`=0 gives `move_done` at n+2 with no motion;
  - a `move_start` while `busy` is ignored;
  - `home` and `move_start` in the same cycle in IDLE give tile 0 and no move.
- Reset mid-hop: `reset` asserted halfway through a hop restores tile 0 immediately.
- With `PLAYER_MOVER_DWELL_EN` and `steps`=2: exactly 6 idle ticks occur between the two hops.

Source files
------------

// File: rtl/board_pkg.sv
// Shared board constants and mover state encoding for the token animator and board renderer.
// PLAYER_MOVER_DWELL_EN adds the DWELL state to the mover enum.
package board_pkg;

    localparam int DEF_NUM_TILES    = 32;
    localparam int DEF_COLS         = 8;
    localparam int DEF_TILE_PX      = 32;
    localparam int DEF_ORIGIN_X     = 64;
    localparam int DEF_ORIGIN_Y     = 96;
    localparam int DEF_SPEED        = 4;
    localparam int DEF_DWELL_FRAMES = 6;

    localparam int SPRITE_PX = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOP   = 2'd1,
`ifdef PLAYER_MOVER_DWELL_EN
        ST_DWELL = 2'd2,
`endif
        ST_DONE  = 2'd3
    } mover_state_e;

endpackage

// File: rtl/tile_coord_lut.sv
// Combinational map from serpentine tile index to sprite top-left screen coordinates.
// Indices past the last tile clamp to the goal tile.
module tile_coord_lut
    import board_pkg::*;
#(
    parameter int NUM_TILES = DEF_NUM_TILES,
    parameter int COLS      = DEF_COLS,
    parameter int TILE_PX   = DEF_TILE_PX,
    parameter int ORIGIN_X  = DEF_ORIGIN_X,
    parameter int ORIGIN_Y  = DEF_ORIGIN_Y
) (
    input  logic [4:0] idx_i,
    output logic [9:0] x_o,
    output logic [9:0] y_o
);

    always_comb begin
        int idx;
        int r;
        int c;
        idx = int'(idx_i);
        if (idx > NUM_TILES - 1) idx = NUM_TILES - 1;
        r = idx / COLS;
        c = idx % COLS;
        // odd rows run right-to-left
        if ((r % 2) != 0) c = COLS - 1 - c;
        x_o = 10'(ORIGIN_X + c * TILE_PX + (TILE_PX - SPRITE_PX) / 2);
        y_o = 10'(ORIGIN_Y + r * TILE_PX + (TILE_PX - SPRITE_PX) / 2);
    end

endmodule

// File: rtl/player_mover.sv
// Walks one player's token tile by tile along the serpentine path, gliding SPEED px per frame.
// Optional PLAYER_MOVER_DWELL_EN inserts a DWELL_FRAMES pause on each intermediate tile.
module player_mover
    import board_pkg::*;
#(
    parameter int NUM_TILES    = DEF_NUM_TILES,
    parameter int COLS         = DEF_COLS,
    parameter int TILE_PX      = DEF_TILE_PX,
    parameter int ORIGIN_X     = DEF_ORIGIN_X,
    parameter int ORIGIN_Y     = DEF_ORIGIN_Y,
    parameter int SPEED        = DEF_SPEED,
    parameter int DWELL_FRAMES = DEF_DWELL_FRAMES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       move_start,
    input  logic [2:0] steps,
    input  logic       home,
    output logic [9:0] player_x,
    output logic [9:0] player_y,
    output logic [4:0] tile_idx,
    output logic       busy,
    output logic       move_done,
    output logic       at_goal
);

    localparam logic [4:0] GOAL   = 5'(NUM_TILES - 1);
    localparam logic [9:0] HOME_X = 10'(ORIGIN_X + (TILE_PX - SPRITE_PX) / 2);
    localparam logic [9:0] HOME_Y = 10'(ORIGIN_Y + (TILE_PX - SPRITE_PX) / 2);
    localparam logic [9:0] STEP   = 10'(SPEED);

    if (SPEED < 1 || COLS < 1 || DWELL_FRAMES < 1) begin : g_param_check
        $error("player_mover: SPEED, COLS and DWELL_FRAMES must be positive");
    end

    mover_state_e state_q, state_d;
    logic [4:0]   tile_q, tile_d;
    logic [2:0]   rem_q, rem_d;
    logic [9:0]   x_q, x_d, y_q, y_d;
    logic         at_goal_q, at_goal_d;

    logic [4:0]   next_idx;
    logic [9:0]   tgt_x, tgt_y;
    logic [9:0]   x_step, y_step;

`ifdef PLAYER_MOVER_DWELL_EN
    localparam int DW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES + 1) : 1;
    logic [DW-1:0] dwell_q, dwell_d;
`endif

    // Only one axis differs between neighbours, so gliding both axes is safe.
    function automatic logic [9:0] glide(input logic [9:0] cur, input logic [9:0] tgt);
        if (tgt > cur)      glide = ((tgt - cur) <= STEP) ? tgt : cur + STEP;
        else if (cur > tgt) glide = ((cur - tgt) <= STEP) ? tgt : cur - STEP;
        else                glide = cur;
    endfunction

    assign next_idx = tile_q + 5'd1;

    tile_coord_lut #(
        .NUM_TILES (NUM_TILES),
        .COLS      (COLS),
        .TILE_PX   (TILE_PX),
        .ORIGIN_X  (ORIGIN_X),
        .ORIGIN_Y  (ORIGIN_Y)
    ) u_target_lut (
        .idx_i (next_idx),
        .x_o   (tgt_x),
        .y_o   (tgt_y)
    );

    assign x_step = glide(x_q, tgt_x);
    assign y_step = glide(y_q, tgt_y);

    always_comb begin
        state_d = state_q;
        tile_d  = tile_q;
        rem_d   = rem_q;
        x_d     = x_q;
        y_d     = y_q;
`ifdef PLAYER_MOVER_DWELL_EN
        dwell_d = dwell_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (home) begin
                    tile_d = 5'd0;
                    x_d    = HOME_X;
                    y_d    = HOME_Y;
                end else if (move_start) begin
                    rem_d   = steps;
                    state_d = ST_HOP;
                end
            end
            ST_HOP: begin
                if (rem_q == 3'd0 || at_goal_q) begin
                    state_d = ST_DONE;
                end else if (frame_tick) begin
                    x_d = x_step;
                    y_d = y_step;
                    if (x_step == tgt_x && y_step == tgt_y) begin
                        tile_d = next_idx;
                        rem_d  = rem_q - 3'd1;
                        // steps left over once the goal is reached are dropped
                        if (rem_q == 3'd1 || next_idx == GOAL) begin
                            state_d = ST_DONE;
                        end else begin
`ifdef PLAYER_MOVER_DWELL_EN
                            state_d = ST_DWELL;
                            dwell_d = DW'(DWELL_FRAMES);
`endif
                        end
                    end
                end
            end
`ifdef PLAYER_MOVER_DWELL_EN
            ST_DWELL: begin
                if (frame_tick) begin
                    if (dwell_q == DW'(1)) state_d = ST_HOP;
                    else                   dwell_d = dwell_q - DW'(1);
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        at_goal_d = (tile_d == GOAL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tile_q    <= 5'd0;
            rem_q     <= 3'd0;
            x_q       <= HOME_X;
            y_q       <= HOME_Y;
            at_goal_q <= 1'b0;
`ifdef PLAYER_MOVER_DWELL_EN
            dwell_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            tile_q    <= tile_d;
            rem_q     <= rem_d;
            x_q       <= x_d;
            y_q       <= y_d;
            at_goal_q <= at_goal_d;
`ifdef PLAYER_MOVER_DWELL_EN
            dwell_q   <= dwell_d;
`endif
        end
    end

    assign player_x  = x_q;
    assign player_y  = y_q;
    assign tile_idx  = tile_q;
    assign at_goal   = at_goal_q;
    assign move_done = (state_q == ST_DONE);
`ifdef PLAYER_MOVER_DWELL_EN
    assign busy      = (state_q == ST_HOP) || (state_q == ST_DWELL);
`else
    assign busy      = (state_q == ST_HOP);
`endif

endmodule

// File: tb/tb_player_mover.sv
// Directed bench for player_mover with default parameters and a frame_tick every 100 clocks.
// Build with PLAYER_MOVER_DWELL_EN to also cover the per-tile dwell.
module tb_player_mover;

    localparam int TICK_PER = 100;
    localparam int HOP_T    = 8;
    localparam int BUDGET   = 20000;
`ifdef PLAYER_MOVER_DWELL_EN
    localparam int DW = 6;
`else
    localparam int DW = 0;
`endif

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic       move_start;
    logic [2:0] steps;
    logic       home;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic [4:0] tile_idx;
    logic       busy;
    logic       move_done;
    logic       at_goal;

    int n_vec = 0;
    int n_err = 0;

    player_mover dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .move_start (move_start),
        .steps      (steps),
        .home       (home),
        .player_x   (player_x),
        .player_y   (player_y),
        .tile_idx   (tile_idx),
        .busy       (busy),
        .move_done  (move_done),
        .at_goal    (at_goal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        frame_tick = 1'b0;
        forever begin
            repeat (TICK_PER - 1) @(posedge clk);
            #1 frame_tick = 1'b1;
            @(posedge clk);
            #1 frame_tick = 1'b0;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic do_move(input int s);
        @(posedge clk);
        #1;
        steps      = 3'(s);
        move_start = 1'b1;
        @(posedge clk);
        #1 move_start = 1'b0;
    endtask

    task automatic wait_done(output int ticks, output int x_first, output bit ok);
        ticks   = 0;
        x_first = -1;
        ok      = 1'b0;
        for (int i = 0; i < BUDGET && !ok; i++) begin
            @(posedge clk);
            if (frame_tick) ticks++;
            #1;
            if (ticks == 1 && x_first < 0) x_first = int'(player_x);
            if (move_done) ok = 1'b1;
        end
    endtask

    task automatic wait_tile(input int idx, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET && !ok; i++) begin
            @(posedge clk);
            #1;
            if (int'(tile_idx) == idx) ok = 1'b1;
        end
    endtask

    initial begin
        int t;
        int xf;
        bit ok;
        reset      = 1'b1;
        move_start = 1'b0;
        steps      = 3'd0;
        home       = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_x", int'(player_x), 72);
        chk("rst_y", int'(player_y), 104);
        chk("rst_tile", int'(tile_idx), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(move_done), 0);
        chk("rst_goal", int'(at_goal), 0);
        repeat (300) @(posedge clk);
        #1;
        chk("idle_x", int'(player_x), 72);
        chk("idle_tile", int'(tile_idx), 0);

        // three steps along row 0
        do_move(3);
        chk("s3_busy_n1", int'(busy), 1);
        wait_done(t, xf, ok);
        chk("s3_done_seen", int'(ok), 1);
        chk("s3_ticks", t, 3 * HOP_T + 2 * DW);
        chk("s3_first_x", xf, 76);
        chk("s3_tile", int'(tile_idx), 3);
        chk("s3_x", int'(player_x), 168);
        chk("s3_y", int'(player_y), 104);
        chk("s3_busy_done", int'(busy), 0);
        @(posedge clk);
        #1 chk("s3_done_pulse", int'(move_done), 0);

        // zero-step move
        do_move(0);
        chk("z_busy_n1", int'(busy), 1);
        chk("z_done_n1", int'(move_done), 0);
        @(posedge clk);
        #1;
        chk("z_done_n2", int'(move_done), 1);
        chk("z_busy_n2", int'(busy), 0);
        chk("z_x", int'(player_x), 168);
        chk("z_tile", int'(tile_idx), 3);

        do_move(3);
        wait_done(t, xf, ok);
        chk("to6_tile", int'(tile_idx), 6);
        chk("to6_x", int'(player_x), 264);

        // row turn
        do_move(2);
        wait_tile(7, ok);
        chk("rt_t7_seen", int'(ok), 1);
        chk("rt_t7_x", int'(player_x), 296);
        chk("rt_t7_y", int'(player_y), 104);
        wait_done(t, xf, ok);
        chk("rt_done_seen", int'(ok), 1);
        chk("rt_tile", int'(tile_idx), 8);
        chk("rt_x", int'(player_x), 296);
        chk("rt_y", int'(player_y), 136);

        // move_start while busy must be ignored
        do_move(1);
        repeat (250) @(posedge clk);
        #1;
        steps      = 3'd7;
        move_start = 1'b1;
        @(posedge clk);
        #1 move_start = 1'b0;
        wait_done(t, xf, ok);
        chk("ign_done_seen", int'(ok), 1);
        chk("ign_tile", int'(tile_idx), 9);
        chk("ign_x", int'(player_x), 264);
        chk("ign_y", int'(player_y), 136);
        repeat (1000) @(posedge clk);
        #1;
        chk("ign_tile_after", int'(tile_idx), 9);
        chk("ign_busy_after", int'(busy), 0);

        do_move(7);
        wait_done(t, xf, ok);
        do_move(7);
        wait_done(t, xf, ok);
        do_move(6);
        wait_done(t, xf, ok);
        chk("to29_tile", int'(tile_idx), 29);
        chk("to29_goal", int'(at_goal), 0);

        // overshoot past the goal
        do_move(5);
        wait_done(t, xf, ok);
        chk("ov_done_seen", int'(ok), 1);
        chk("ov_ticks", t, 2 * HOP_T + DW);
        chk("ov_tile", int'(tile_idx), 31);
        chk("ov_x", int'(player_x), 72);
        chk("ov_y", int'(player_y), 200);
        chk("ov_goal", int'(at_goal), 1);
        do_move(3);
        @(posedge clk);
        #1;
        chk("goal_done_n2", int'(move_done), 1);
        chk("goal_tile", int'(tile_idx), 31);
        chk("goal_y", int'(player_y), 200);

        // home beats a simultaneous move_start
        @(posedge clk);
        #1;
        home       = 1'b1;
        move_start = 1'b1;
        steps      = 3'd4;
        @(posedge clk);
        #1;
        home       = 1'b0;
        move_start = 1'b0;
        chk("home_tile", int'(tile_idx), 0);
        chk("home_x", int'(player_x), 72);
        chk("home_y", int'(player_y), 104);
        chk("home_goal", int'(at_goal), 0);
        chk("home_busy", int'(busy), 0);
        repeat (300) @(posedge clk);
        #1;
        chk("home_still_x", int'(player_x), 72);

`ifdef PLAYER_MOVER_DWELL_EN
        begin
            int cnt;
            int x1;
            bit moved;
            do_move(2);
            wait_tile(1, ok);
            chk("dw_t1_seen", int'(ok), 1);
            chk("dw_t1_x", int'(player_x), 104);
            x1    = int'(player_x);
            cnt   = 0;
            moved = 1'b0;
            for (int i = 0; i < BUDGET && !moved; i++) begin
                @(posedge clk);
                if (frame_tick) cnt++;
                #1;
                if (int'(player_x) != x1) moved = 1'b1;
            end
            chk("dw_moved", int'(moved), 1);
            chk("dw_idle_ticks", cnt - 1, 6);
            wait_done(t, xf, ok);
            chk("dw_tile", int'(tile_idx), 2);
            @(posedge clk);
            #1 home = 1'b1;
            @(posedge clk);
            #1 home = 1'b0;
        end
`endif

        // reset halfway through a hop
        do_move(1);
        t = 0;
        for (int i = 0; i < BUDGET && t < 4; i++) begin
            @(posedge clk);
            if (frame_tick) t++;
        end
        #1;
        chk("mid_x", int'(player_x), 88);
        #3 reset = 1'b1;
        #1;
        chk("mr_x", int'(player_x), 72);
        chk("mr_y", int'(player_y), 104);
        chk("mr_tile", int'(tile_idx), 0);
        chk("mr_busy", int'(busy), 0);
        chk("mr_done", int'(move_done), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        chk("mr_after_x", int'(player_x), 72);
        chk("mr_after_busy", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
